game_state_ctrl: RTL and testbench

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_state_ctrl.sv | 151 +++++++++++++++
 tb/tb_game_state_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Frogger game sequencer: start detection, hazard checking with post-hit grace,
// lives bookkeeping, win hold and an end-of-game cleanup window. All outputs registered.
module game_state_ctrl #(
  parameter int c_GAME_WIDTH     = 20,
  parameter int c_GAME_HEIGHT    = 15,
  parameter int c_LIVES          = 3,
  parameter int c_GRACE_FRAMES   = 60,
  parameter int c_WIN_FRAMES     = 120,
  parameter int c_CLEANUP_CYCLES = 16
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Game_Start,
  input  logic        i_Frame_Tick,
  input  logic [5:0]  i_Frogger_X,
  input  logic [5:0]  i_Frogger_Y,
  input  logic [3:0]  i_Tile,
  input  logic        i_On_Log,
  input  logic [29:0] i_Car_X,
  input  logic [29:0] i_Car_Y,
  output logic [1:0]  o_State,
  output logic        o_Game_Active,
  output logic        o_Collided,
  output logic [1:0]  o_Lives,
  output logic        o_Frog_Reset
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUNNING = 2'b01,
    S_WINS    = 2'b10,
    S_CLEANUP = 2'b11
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(c_LIVES);
  localparam logic [7:0] GRACE_INIT = 8'(c_GRACE_FRAMES);
  localparam logic [7:0] WIN_LAST   = 8'(c_WIN_FRAMES - 1);
  localparam logic [7:0] CLEAN_LAST = 8'(c_CLEANUP_CYCLES - 1);
  localparam logic [6:0] WIDTH_LIM  = 7'(c_GAME_WIDTH);
  localparam logic [6:0] HEIGHT_LIM = 7'(c_GAME_HEIGHT);

  state_t      state_q;
  logic        start_prev_q;
  logic [1:0]  lives_q;
  logic [7:0]  grace_q;
  logic [7:0]  cnt_q;
  logic        active_q;
  logic        collided_q;
  logic        frog_reset_q;

  logic        start_press;
  logic        car_hit;
  logic        hazard;

  // Previous-sample register resets high so a button held through reset never starts a game.
  assign start_press = i_Game_Start & ~start_prev_q;

  always_comb begin
    car_hit = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if ((i_Car_X[6*n +: 6] == i_Frogger_X) && (i_Car_Y[6*n +: 6] == i_Frogger_Y)) begin
        car_hit = 1'b1;
      end
    end
  end

  assign hazard = car_hit
                | ((i_Tile == 4'd2) & ~i_On_Log)
                | (i_Tile == 4'd0)
                | ({1'b0, i_Frogger_X} >= WIDTH_LIM)
                | ({1'b0, i_Frogger_Y} >= HEIGHT_LIM);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b1;
      lives_q      <= LIVES_INIT;
      grace_q      <= 8'd0;
      cnt_q        <= 8'd0;
      active_q     <= 1'b0;
      collided_q   <= 1'b0;
      frog_reset_q <= 1'b0;
    end else begin
      start_prev_q <= i_Game_Start;
      collided_q   <= 1'b0;
      frog_reset_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_press) begin
            state_q      <= S_RUNNING;
            lives_q      <= LIVES_INIT;
            grace_q      <= 8'd0;
            active_q     <= 1'b1;
            frog_reset_q <= 1'b1;
          end
        end
        S_RUNNING: begin
          if (hazard && (grace_q == 8'd0)) begin
            collided_q   <= 1'b1;
            frog_reset_q <= 1'b1;
            grace_q      <= GRACE_INIT;
            if (lives_q <= 2'd1) begin
              lives_q  <= 2'd0;
              state_q  <= S_CLEANUP;
              cnt_q    <= 8'd0;
              active_q <= 1'b0;
            end else begin
              lives_q <= lives_q - 2'd1;
            end
          end else begin
            if (i_Frame_Tick && (grace_q != 8'd0)) begin
              grace_q <= grace_q - 8'd1;
            end
            // Any hazard on the lily pad, even one masked by grace, blocks the win.
            if (!hazard && (i_Tile == 4'd4)) begin
              state_q  <= S_WINS;
              cnt_q    <= 8'd0;
              active_q <= 1'b0;
            end
          end
        end
        S_WINS: begin
          if (start_press || (i_Frame_Tick && (cnt_q == WIN_LAST))) begin
            state_q      <= S_CLEANUP;
            cnt_q        <= 8'd0;
            frog_reset_q <= 1'b1;
          end else if (i_Frame_Tick) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_CLEANUP: begin
          if (cnt_q == CLEAN_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            lives_q <= LIVES_INIT;
          end else begin
            cnt_q        <= cnt_q + 8'd1;
            frog_reset_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign o_State       = state_q;
  assign o_Game_Active = active_q;
  assign o_Collided    = collided_q;
  assign o_Lives       = lives_q;
  assign o_Frog_Reset  = frog_reset_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: per-cycle {inputs, expected outputs} records driven through
// a scoreboard queue, with tables for the opening/boundary cases and loops for long holds.
module tb_game_state_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        tick;
  logic [5:0]  fx;
  logic [5:0]  fy;
  logic [3:0]  tile;
  logic        on_log;
  logic [29:0] cx;
  logic [29:0] cy;
  logic [1:0]  o_state;
  logic        o_active;
  logic        o_coll;
  logic [1:0]  o_lives;
  logic        o_frog;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] exp_q[$];

  typedef struct {
    logic        start;
    logic        tick;
    logic [5:0]  fx;
    logic [5:0]  fy;
    logic [3:0]  tile;
    logic        on_log;
    logic [29:0] cx;
    logic [29:0] cy;
    logic [6:0]  exp;
  } vec_t;

  vec_t tbl[8];
  vec_t bnd[4];

  always #5 clk = ~clk;

  game_state_ctrl dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Game_Start (start),
    .i_Frame_Tick (tick),
    .i_Frogger_X  (fx),
    .i_Frogger_Y  (fy),
    .i_Tile       (tile),
    .i_On_Log     (on_log),
    .i_Car_X      (cx),
    .i_Car_Y      (cy),
    .o_State      (o_state),
    .o_Game_Active(o_active),
    .o_Collided   (o_coll),
    .o_Lives      (o_lives),
    .o_Frog_Reset (o_frog)
  );

  // Expected output word: {state, active, collided, lives, frog_reset}.
  function automatic logic [6:0] e(input int st, input int act, input int col, input int lv,
                                   input int fr);
    return {2'(st), 1'(act), 1'(col), 2'(lv), 1'(fr)};
  endfunction

  // All cars parked at (63,63); car n (if n >= 0) placed at value v.
  function automatic logic [29:0] car_at(input int n, input logic [5:0] v);
    logic [29:0] r;
    r = {5{6'h3F}};
    if (n >= 0) r[6*n +: 6] = v;
    return r;
  endfunction

  // car >= 0 puts that car exactly on the frog.
  function automatic vec_t mk(input int s, input int t, input int x, input int y, input int tl,
                              input int lg, input int car, input logic [6:0] ex);
    vec_t v;
    v.start  = 1'(s);
    v.tick   = 1'(t);
    v.fx     = 6'(x);
    v.fy     = 6'(y);
    v.tile   = 4'(tl);
    v.on_log = 1'(lg);
    v.cx     = car_at(car, 6'(x));
    v.cy     = car_at(car, 6'(y));
    v.exp    = ex;
    return v;
  endfunction

  task automatic check_out(input string name);
    logic [6:0] act;
    logic [6:0] want;
    act = {o_state, o_active, o_coll, o_lives, o_frog};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %b", name, act);
    end else begin
      want = exp_q.pop_front();
      if (act !== want) begin
        n_fail++;
        $display("FAIL %s: got state=%b active=%b coll=%b lives=%0d frog=%b, expected state=%b active=%b coll=%b lives=%0d frog=%b",
                 name, act[6:5], act[4], act[3], act[2:1], act[0],
                 want[6:5], want[4], want[3], want[2:1], want[0]);
      end
    end
  endtask

  task automatic drive(input vec_t v, input string name);
    start  = v.start;
    tick   = v.tick;
    fx     = v.fx;
    fy     = v.fy;
    tile   = v.tile;
    on_log = v.on_log;
    cx     = v.cx;
    cy     = v.cy;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  // Burns down a full grace window on safe tiles at random in-field positions.
  task automatic tickdown(input int lives);
    for (int i = 0; i < 60; i++) begin
      drive(mk(0, 1, $urandom_range(0, 19), $urandom_range(0, 14), 3, 0, -1,
               e(1, 1, 0, lives, 0)), "grace_tickdown");
    end
  endtask

  task automatic cleanup_tail(input int s, input int lives, input int tl);
    for (int i = 0; i < 15; i++) begin
      drive(mk(s, 0, 7, 3, tl, 0, -1, e(3, 0, 0, lives, 1)), "cleanup_hold");
    end
    drive(mk(s, 0, 7, 3, tl, 0, -1, e(0, 0, 0, 3, 0)), "cleanup_done");
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b1;
    tick   = 1'b0;
    fx     = 6'd10;
    fy     = 6'd5;
    tile   = 4'd3;
    on_log = 1'b0;
    cx     = car_at(-1, 6'd0);
    cy     = car_at(-1, 6'd0);

    tbl[0] = mk(1, 0, 10, 5, 3, 0, -1, e(0, 0, 0, 3, 0));
    tbl[1] = mk(1, 0, 10, 5, 3, 0, -1, e(0, 0, 0, 3, 0));
    tbl[2] = mk(0, 0, 10, 5, 3, 0, -1, e(0, 0, 0, 3, 0));
    tbl[3] = mk(1, 0, 10, 5, 3, 0, -1, e(1, 1, 0, 3, 1));
    tbl[4] = mk(1, 0, 10, 5, 3, 0, -1, e(1, 1, 0, 3, 0));
    tbl[5] = mk(0, 0, 10, 5, 3, 0, -1, e(1, 1, 0, 3, 0));
    tbl[6] = mk(1, 0, 10, 5, 3, 0, -1, e(1, 1, 0, 3, 0));
    tbl[7] = mk(0, 0, 5, 11, 3, 0, 2, e(1, 1, 1, 2, 1));

    bnd[0] = mk(1, 0, 10, 5, 3, 0, -1, e(1, 1, 0, 3, 1));
    bnd[1] = mk(0, 0, 19, 14, 3, 0, -1, e(1, 1, 0, 3, 0));
    bnd[2] = mk(0, 0, 20, 5, 3, 0, -1, e(1, 1, 1, 2, 1));
    bnd[3] = mk(0, 0, 10, 5, 3, 0, -1, e(1, 1, 0, 2, 0));

    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(e(0, 0, 0, 3, 0));
    check_out("reset_hold");
    rst_n = 1'b1;

    // Start held through reset, then a real press, held/repeated presses, first car hit.
    for (int i = 0; i < 8; i++) drive(tbl[i], $sformatf("tbl[%0d]", i));

    // Car 2 stays on the frog: 59 frames safe, the 60th tick clears grace, then a hit.
    for (int i = 0; i < 59; i++) begin
      drive(mk(0, 1, 5, 11, 3, 0, 2, e(1, 1, 0, 2, 0)), "grace_tick");
      drive(mk(0, 0, 5, 11, 3, 0, 2, e(1, 1, 0, 2, 0)), "grace_hold");
    end
    drive(mk(0, 1, 5, 11, 3, 0, 2, e(1, 1, 0, 2, 0)), "grace_last_tick");
    drive(mk(0, 0, 5, 11, 3, 0, 2, e(1, 1, 1, 1, 1)), "grace_expired_hit");

    tickdown(1);
    drive(mk(0, 0, 7, 3, 2, 1, -1, e(1, 1, 0, 1, 0)), "water_on_log");
    drive(mk(0, 0, 7, 3, 2, 0, -1, e(3, 0, 1, 0, 1)), "water_last_life");
    cleanup_tail(0, 0, 2);

    // Game 2: hazard beats the lily pad, then a clean win held for 120 ticks.
    drive(mk(1, 0, 5, 11, 3, 0, -1, e(1, 1, 0, 3, 1)), "g2_start");
    drive(mk(1, 0, 5, 11, 4, 0, 0, e(1, 1, 1, 2, 1)), "lily_with_car");
    drive(mk(1, 0, 5, 11, 4, 0, -1, e(2, 0, 0, 2, 0)), "lily_win");
    drive(mk(1, 0, 5, 11, 0, 0, 0, e(2, 0, 0, 2, 0)), "win_ignores_hazard");
    for (int i = 0; i < 119; i++) begin
      drive(mk(1, 1, 5, 11, 0, 0, 0, e(2, 0, 0, 2, 0)), "win_tick");
      drive(mk(1, 0, 5, 11, 0, 0, 0, e(2, 0, 0, 2, 0)), "win_hold");
    end
    drive(mk(1, 1, 5, 11, 3, 0, -1, e(3, 0, 0, 2, 1)), "win_timeout");
    cleanup_tail(1, 2, 3);

    // Game 3: a press during the win display jumps straight to cleanup.
    drive(mk(0, 0, 10, 5, 3, 0, -1, e(0, 0, 0, 3, 0)), "g3_release");
    drive(mk(1, 0, 10, 5, 3, 0, -1, e(1, 1, 0, 3, 1)), "g3_start");
    drive(mk(0, 0, 10, 5, 4, 0, -1, e(2, 0, 0, 3, 0)), "g3_win");
    drive(mk(1, 0, 10, 5, 3, 0, -1, e(3, 0, 0, 3, 1)), "win_start_abort");
    cleanup_tail(1, 3, 3);
    drive(mk(1, 0, 10, 5, 3, 0, -1, e(0, 0, 0, 3, 0)), "held_no_restart");
    drive(mk(0, 0, 10, 5, 3, 0, -1, e(0, 0, 0, 3, 0)), "g4_release");

    // Game 4: playfield edges and the wall tile.
    for (int i = 0; i < 4; i++) drive(bnd[i], $sformatf("bnd[%0d]", i));
    tickdown(2);
    drive(mk(0, 0, 10, 14, 3, 0, -1, e(1, 1, 0, 2, 0)), "y_edge_ok");
    drive(mk(0, 0, 10, 15, 3, 0, -1, e(1, 1, 1, 1, 1)), "y_out_hit");
    tickdown(1);
    drive(mk(0, 0, 10, 5, 0, 0, -1, e(3, 0, 1, 0, 1)), "wall_last_life");
    cleanup_tail(0, 0, 3);

    // Game 5: asynchronous reset in the middle of play.
    drive(mk(1, 0, 10, 5, 3, 0, -1, e(1, 1, 0, 3, 1)), "g5_start");
    drive(mk(1, 0, 10, 5, 0, 0, -1, e(1, 1, 1, 2, 1)), "g5_wall_hit");
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    exp_q.push_back(e(0, 0, 0, 3, 0));
    check_out("async_reset");
    @(posedge clk);
    #1;
    exp_q.push_back(e(0, 0, 0, 3, 0));
    check_out("async_reset_held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(mk(1, 0, 10, 5, 3, 0, -1, e(0, 0, 0, 3, 0)), "start_held_after_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
